// File: rtl/main_decoder_staged.sv
// Registered main decoder: one output stage with valid/ready handshake and an
// optional hardware link stack that pushes the return PC on BL and pops it on RET.
module main_decoder_staged #(
  parameter int PC_W        = 32,
  parameter int STACK_DEPTH = 8,
  parameter bit HW_LINK     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     tipo,
  input  logic [1:0]                     op,
  input  logic                           inm,
  input  logic [PC_W-1:0]                pc_next,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           RegWrite,
  output logic                           ALUSrc,
  output logic                           MemWrite,
  output logic                           ResultSrc,
  output logic                           Branch,
  output logic                           Jump,
  output logic                           PCDirection,
  output logic                           PCReturnSignal,
  output logic [1:0]                     ImmSrc,
  output logic [1:0]                     ALUOp,
  output logic [1:0]                     RGB,
  output logic [PC_W-1:0]                ret_addr,
  output logic                           ret_hit,
  output logic [$clog2(STACK_DEPTH):0]   stack_count,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic        accept;
  logic        is_bl;
  logic        is_ret;
  logic        out_valid_reg;
  logic [13:0] word_reg;
  logic [13:0] word_next;

  logic       reg_write_next, alu_src_next, mem_write_next, result_src_next;
  logic       jump_next, pc_dir_next, pc_ret_next;
  logic [1:0] imm_src_next, alu_op_next, rgb_next;

  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready && !flush && !rst;
  assign is_bl     = (tipo == 2'b10) && (op == 2'b01);
  assign is_ret    = (tipo == 2'b11) && (op == 2'b00);
  assign out_valid = out_valid_reg;

  always_comb begin
    reg_write_next  = 1'b0;
    alu_src_next    = 1'b0;
    mem_write_next  = 1'b0;
    result_src_next = 1'b0;
    jump_next       = 1'b0;
    pc_dir_next     = 1'b0;
    pc_ret_next     = 1'b0;
    imm_src_next    = 2'b00;
    alu_op_next     = 2'b00;
    rgb_next        = 2'b00;
    case (tipo)
      2'b00: begin
        reg_write_next = 1'b1;
        alu_src_next   = inm;
        alu_op_next    = 2'b10;
      end
      2'b01: begin
        reg_write_next = 1'b1;
        alu_src_next   = inm;
        if (op != 2'b00) begin
          result_src_next = 1'b1;
          rgb_next        = op;
        end
      end
      2'b10: begin
        case (op)
          2'b00: begin
            jump_next    = 1'b1;
            imm_src_next = 2'b10;
            pc_dir_next  = inm;
          end
          2'b01: begin
            jump_next      = 1'b1;
            imm_src_next   = 2'b10;
            reg_write_next = 1'b1;
          end
          2'b10:   alu_op_next = 2'b01;
          default: ;
        endcase
      end
      default: begin
        alu_src_next = inm;
        if (op == 2'b00) begin
          jump_next   = 1'b1;
          pc_ret_next = 1'b1;
        end else begin
          mem_write_next = 1'b1;
          rgb_next       = op;
        end
      end
    endcase
    word_next = {reg_write_next, alu_src_next, mem_write_next, result_src_next,
                 1'b0, jump_next, pc_dir_next, pc_ret_next,
                 imm_src_next, alu_op_next, rgb_next};
  end

  // A held word (stall or drain) keeps its fields; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      word_reg      <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      word_reg      <= word_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, PCDirection,
          PCReturnSignal, ImmSrc, ALUOp, RGB} = word_reg;

  generate
    if (HW_LINK) begin : g_link
      localparam logic [PTR_W-1:0] PTR_ONE = 1;

      logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
      logic [PC_W-1:0]  rd_reg;
      logic [PTR_W-1:0] ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             ovf_reg, unf_reg, hit_reg;
      logic             full, empty, push, pop;

      assign full  = (count_reg == CNT_W'(STACK_DEPTH));
      assign empty = (count_reg == '0);
      assign push  = accept && is_bl;
      assign pop   = accept && is_ret && !empty;

      // Storage carries no reset so it maps to block RAM; hit_reg masks stale data.
      always_ff @(posedge clk) begin
        if (push)
          stack_mem[ptr_reg] <= pc_next;
        if (pop)
          rd_reg <= stack_mem[ptr_reg - PTR_ONE];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ptr_reg   <= '0;
          count_reg <= '0;
          ovf_reg   <= 1'b0;
          unf_reg   <= 1'b0;
          hit_reg   <= 1'b0;
        end else if (accept) begin
          hit_reg <= 1'b0;
          if (is_bl) begin
            ptr_reg <= ptr_reg + PTR_ONE;
            if (full)
              ovf_reg <= 1'b1;
            else
              count_reg <= count_reg + 1'b1;
          end else if (is_ret) begin
            if (empty) begin
              unf_reg <= 1'b1;
            end else begin
              ptr_reg   <= ptr_reg - PTR_ONE;
              count_reg <= count_reg - 1'b1;
              hit_reg   <= 1'b1;
            end
          end
        end
      end

      assign ret_addr    = hit_reg ? rd_reg : '0;
      assign ret_hit     = hit_reg;
      assign stack_count = count_reg;
      assign stack_ovf   = ovf_reg;
      assign stack_unf   = unf_reg;
    end else begin : g_no_link
      assign ret_addr    = '0;
      assign ret_hit     = 1'b0;
      assign stack_count = '0;
      assign stack_ovf   = 1'b0;
      assign stack_unf   = 1'b0;
    end
  endgenerate

endmodule

// File: doc/main_decoder_staged.md
Name: main_decoder_staged

Overview:
- Registered, parametrised successor of the single-cycle main decoder.
- Decodes tipo/op/inm into the datapath control word and holds it in one output stage with a valid/ready handshake.
- Adds a hardware link stack for BL/RET: BL pushes the return PC, RET pops it.
- Sits between instruction fetch and the register-file/ALU/memory control stage.

Parameters:
- PC_W, 32, width of return-address values.
- STACK_DEPTH, 8, link-stack entries; power of two, at least 2.
- HW_LINK, 1, 1 = RET takes its address from the link stack; 0 = no stack, RET relies on PCReturnSignal only (link register path).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  stage can accept.
- tipo  in  2  instruction type.
- op  in  2  operation.
- inm  in  1  immediate bit.
- pc_next  in  PC_W  return address pushed on BL.
- flush  in  1  squash the stage content and the same-cycle input.
- out_valid  out  1  control word valid.
- out_ready  in  1  consumer accepts.
- RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, PCDirection, PCReturnSignal  out  1 each  control bits.
- ImmSrc, ALUOp, RGB  out  2 each  control fields.
- ret_addr  out  PC_W  popped return address, valid with a RET word.
- ret_hit  out  1  ret_addr comes from a valid stack entry.
- stack_count  out  clog2(STACK_DEPTH)+1  occupied entries.
- stack_ovf  out  1  sticky: a push happened while full.
- stack_unf  out  1  sticky: a pop happened while empty.

Behaviour:
- Reset values: all control outputs 0, ret_addr 0, ret_hit 0, out_valid 0, stack_count 0, ovf/unf 0, stack pointer 0.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready && !flush. Latency is 1 cycle: the word is registered on accept, and out_valid=1 the next cycle.
- If out_valid && !out_ready, all outputs hold stable.
- If out_ready && no accept, out_valid goes to 0 and the other outputs keep their last value.
- Flush: out_valid goes to 0 next cycle; the same-cycle input is discarded with no stack update. Stack contents and flags are kept.
- Decode table (defaults 0):
  - tipo 00: RegWrite=1, ALUSrc=inm, ALUOp=10.
  - tipo 01: ALUSrc=inm, RegWrite=1. op00 gives ResultSrc=0; op01/10/11 give ResultSrc=1 with RGB=01/10/11.
  - tipo 10, op00 (B): Jump=1, ImmSrc=10, PCDirection=inm.
  - tipo 10, op01 (BL): Jump=1, ImmSrc=10, RegWrite=1.
  - tipo 10, op10 (CMP): ALUOp=01.
  - tipo 10, op11: NOP word (all 0), out_valid still 1.
  - tipo 11: ALUSrc=inm. op00 (RET): Jump=1, PCReturnSignal=1. op01/10/11: MemWrite=1 with RGB=01/10/11.
- Link stack (HW_LINK=1), updated only on accept:
  - BL: write pc_next at the pointer, pointer+1 mod STACK_DEPTH, stack_count = min(count+1, DEPTH).
  - BL when full: the oldest entry is overwritten (circular), count stays DEPTH, stack_ovf set.
  - RET when count>0: pointer-1 mod DEPTH, registered ret_addr = entry at the new pointer, ret_hit=1, count-1.
  - RET when empty: ret_addr=0, ret_hit=0, stack_unf set, pointer unchanged.
  - Non-RET accepted words: ret_hit=0, ret_addr=0.
  - Only one push or pop per cycle.
- HW_LINK=0: no storage. ret_hit and count are always 0, flags never set, and RET decodes as in the table.
- Sticky flags clear only on rst. Reset asserted mid-operation overrides accept and flush in the same cycle.

Test Plan:
- Reset, then ADD (tipo00, inm=1) with out_ready=1: next cycle out_valid=1, RegWrite=1, ALUSrc=1, ALUOp=10; all other outputs 0.
- LDG (01/10) held with out_ready=0 for 3 cycles: outputs stable; in_ready=0; a second instruction is not accepted until out_ready=1.
- BL with pc_next=0x100, then BL with 0x200, then RET, RET: ret_addr=0x200 then 0x100, ret_hit=1 both times, count ends 0.
- Third RET with the stack empty: ret_hit=0, ret_addr=0, stack_unf=1 and held after later valid BL/RET pairs.
- DEPTH=8: 9 BLs with pc_next 1..9, then 8 RETs: results 9,8,...,2; count=8 after the pushes; stack_ovf=1.
- BL presented with flush=1: no push (count unchanged), out_valid=0 next cycle. Then rst during a pending STB: all outputs and count 0 the next cycle.
